// File: rtl/ad1868_rx_sequencer.sv
// AD1868-format serial audio receiver. It oversamples CK/DL/DR/LL/LR with the
// system clock and shifts each channel on CK rise. Each word is committed on
// the falling edge of its latch strobe, and completed left/right pairs are
// delivered on a valid/ready handshake.
module ad1868_rx_sequencer #(
    parameter int unsigned WIDTH       = 18,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ck,
    input  logic             i_dl,
    input  logic             i_dr,
    input  logic             i_ll,
    input  logic             i_lr,
    input  logic             i_ready,
    input  logic             i_clr,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_left,
    output logic [WIDTH-1:0] o_right,
    output logic             o_overrun,
    output logic             o_len_err
);

    localparam int unsigned NIN = 5;
    localparam int unsigned CW  = $clog2(WIDTH + 2);
    localparam int unsigned CK  = 0;
    localparam int unsigned DL  = 1;
    localparam int unsigned DR  = 2;
    localparam int unsigned LL  = 3;
    localparam int unsigned LR  = 4;

    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
    logic [NIN-1:0]                  hist_q;
    logic [NIN-1:0]                  pins;
    logic [NIN-1:0]                  s_last;

    logic [WIDTH-1:0] l_sr_q, l_sr_d, r_sr_q, r_sr_d;
    logic [CW-1:0]    l_cnt_q, l_cnt_d, r_cnt_q, r_cnt_d;
    logic [WIDTH-1:0] l_hold_q, l_hold_d, r_hold_q, r_hold_d;
    logic             l_got_q, l_got_d, r_got_q, r_got_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic             ovr_q, ovr_d, len_q, len_d;

    // Post-shift views used by the latch commit and length check
    logic [WIDTH-1:0] l_sr_sh, r_sr_sh;
    logic [CW-1:0]    l_cnt_sh, r_cnt_sh;
    logic             ck_rise, ll_fall, lr_fall;
    logic             buf_free, xfer, ovr_set, len_set;

    assign pins   = {i_lr, i_ll, i_dr, i_dl, i_ck};
    assign s_last = sync_q[SYNC_STAGES-1];

    // Synchronizer chain plus one history stage for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
            hist_q <= s_last;
        end
    end

    // Shift, latch commit, pairing and sticky-flag next-state logic
    always_comb begin
        l_sr_d   = l_sr_q;
        r_sr_d   = r_sr_q;
        l_cnt_d  = l_cnt_q;
        r_cnt_d  = r_cnt_q;
        l_hold_d = l_hold_q;
        r_hold_d = r_hold_q;
        l_got_d  = l_got_q;
        r_got_d  = r_got_q;
        valid_d  = valid_q;
        left_d   = left_q;
        right_d  = right_q;
        ovr_set  = 1'b0;
        len_set  = 1'b0;

        ck_rise = s_last[CK] & ~hist_q[CK];
        ll_fall = ~s_last[LL] & hist_q[LL];
        lr_fall = ~s_last[LR] & hist_q[LR];

        l_sr_sh  = l_sr_q;
        r_sr_sh  = r_sr_q;
        l_cnt_sh = l_cnt_q;
        r_cnt_sh = r_cnt_q;
        if (ck_rise) begin
            l_sr_sh  = {l_sr_q[WIDTH-2:0], s_last[DL]};
            r_sr_sh  = {r_sr_q[WIDTH-2:0], s_last[DR]};
            l_cnt_sh = (l_cnt_q == CW'(WIDTH + 1)) ? l_cnt_q : l_cnt_q + CW'(1);
            r_cnt_sh = (r_cnt_q == CW'(WIDTH + 1)) ? r_cnt_q : r_cnt_q + CW'(1);
        end
        l_sr_d  = l_sr_sh;
        r_sr_d  = r_sr_sh;
        l_cnt_d = l_cnt_sh;
        r_cnt_d = r_cnt_sh;

        buf_free = ~valid_q | i_ready;
        xfer     = l_got_q & r_got_q & buf_free;

        if (xfer) begin
            valid_d = 1'b1;
            left_d  = l_hold_q;
            right_d = r_hold_q;
            l_got_d = 1'b0;
            r_got_d = 1'b0;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end

        if (ll_fall) begin
            l_hold_d = l_sr_sh;
            l_got_d  = 1'b1;
            l_cnt_d  = '0;
            if (l_cnt_sh != CW'(WIDTH)) len_set = 1'b1;
            if (l_got_q & ~xfer)        ovr_set = 1'b1;
        end

        if (lr_fall) begin
            r_hold_d = r_sr_sh;
            r_got_d  = 1'b1;
            r_cnt_d  = '0;
            if (r_cnt_sh != CW'(WIDTH)) len_set = 1'b1;
            if (r_got_q & ~xfer)        ovr_set = 1'b1;
        end

        ovr_d = (ovr_q & ~i_clr) | ovr_set;
        len_d = (len_q & ~i_clr) | len_set;
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            l_sr_q   <= '0;
            r_sr_q   <= '0;
            l_cnt_q  <= '0;
            r_cnt_q  <= '0;
            l_hold_q <= '0;
            r_hold_q <= '0;
            l_got_q  <= 1'b0;
            r_got_q  <= 1'b0;
            valid_q  <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
            ovr_q    <= 1'b0;
            len_q    <= 1'b0;
        end else begin
            l_sr_q   <= l_sr_d;
            r_sr_q   <= r_sr_d;
            l_cnt_q  <= l_cnt_d;
            r_cnt_q  <= r_cnt_d;
            l_hold_q <= l_hold_d;
            r_hold_q <= r_hold_d;
            l_got_q  <= l_got_d;
            r_got_q  <= r_got_d;
            valid_q  <= valid_d;
            left_q   <= left_d;
            right_q  <= right_d;
            ovr_q    <= ovr_d;
            len_q    <= len_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_left    = left_q;
    assign o_right   = right_q;
    assign o_overrun = ovr_q;
    assign o_len_err = len_q;

endmodule

// File: tb/tb_ad1868_rx_sequencer.sv
// Scoreboard bench for ad1868_rx_sequencer: directed scenarios plus randomized frames.
module tb_ad1868_rx_sequencer;

    localparam int unsigned W  = 18;
    localparam int unsigned SS = 2;

    logic         clk = 1'b0;
    logic         rst, ck, dl, dr, ll, lr, ready, clr;
    logic         o_valid, o_overrun, o_len_err;
    logic [W-1:0] o_left, o_right;

    always #5 clk = ~clk;

    ad1868_rx_sequencer #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .i_clk(clk), .i_rst(rst), .i_ck(ck), .i_dl(dl), .i_dr(dr),
        .i_ll(ll), .i_lr(lr), .i_ready(ready), .i_clr(clr),
        .o_valid(o_valid), .o_left(o_left), .o_right(o_right),
        .o_overrun(o_overrun), .o_len_err(o_len_err)
    );

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    pair_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: channel 0 = left, 1 = right
    logic [W-1:0] m_sr   [2];
    logic [W-1:0] m_hold [2];
    int           m_cnt  [2];
    bit           m_got  [2];
    bit           m_obuf, m_ovr, m_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < 2; c++) begin
            m_sr[c] = '0; m_hold[c] = '0; m_cnt[c] = 0; m_got[c] = 0;
        end
        m_obuf = 0; m_ovr = 0; m_len = 0;
        exp_q.delete();
    endfunction

    function automatic void m_settle();
        pair_t p;
        if (m_got[0] && m_got[1] && !m_obuf) begin
            p.l = m_hold[0];
            p.r = m_hold[1];
            exp_q.push_back(p);
            m_obuf = 1;
            m_got[0] = 0;
            m_got[1] = 0;
        end
    endfunction

    function automatic void m_shift(input bit bl, input bit br);
        m_sr[0] = W'({m_sr[0], bl});
        m_sr[1] = W'({m_sr[1], br});
        m_cnt[0]++;
        m_cnt[1]++;
    endfunction

    function automatic void m_latch(input int ch);
        if (m_got[ch]) m_ovr = 1;
        if (m_cnt[ch] != W) m_len = 1;
        m_hold[ch] = m_sr[ch];
        m_got[ch] = 1;
        m_cnt[ch] = 0;
        m_settle();
    endfunction

    // Monitor: every cycle with o_valid the held pair must match the queue head
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: actual left=%0h right=%0h required no sample", o_left, o_right);
            end else begin
                chk("pair", 64'({o_left, o_right}), 64'({exp_q[0].l, exp_q[0].r}));
                if (ready) begin
                    void'(exp_q.pop_front());
                    m_obuf = 0;
                    m_settle();
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch_pin(input int ch);
        if (ch == 0) ll = 1'b0;
        else         lr = 1'b0;
        m_latch(ch);
    endtask

    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int nbits,
                              input int half, input bit do_l, input bit do_r,
                              input bit r_first, input bit coinc);
        bit bl, br;
        for (int i = 0; i < nbits; i++) begin
            bl = lw[nbits-1-i];
            br = rw[nbits-1-i];
            dl = bl; dr = br; ck = 1'b0;
            cyc(half);
            ck = 1'b1;
            m_shift(bl, br);
            if (coinc && do_l && i == nbits - 1) latch_pin(0);
            cyc(half);
        end
        ck = 1'b0;
        cyc(half);
        if (r_first) begin
            if (do_r) begin latch_pin(1); cyc(8); end
            if (do_l) begin latch_pin(0); cyc(8); end
        end else begin
            if (do_l && !coinc) begin latch_pin(0); cyc(8); end
            if (do_r) begin latch_pin(1); cyc(8); end
        end
        ll = 1'b1; lr = 1'b1;
        cyc(8);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_overrun"}, 64'(o_overrun), 64'(m_ovr));
        chk({tag, "_len_err"}, 64'(o_len_err), 64'(m_len));
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        m_ovr = 0;
        m_len = 0;
        cyc(1);
        clr = 1'b0;
        cyc(2);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},   64'(o_valid), 64'(0));
        chk({tag, "_data"},    64'({o_left, o_right}), 64'(0));
        chk({tag, "_flags"},   64'({o_overrun, o_len_err}), 64'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nbits, half;
        bit rf, co;
        rst = 1'b1; ck = 1'b0; dl = 1'b0; dr = 1'b0;
        ll = 1'b1; lr = 1'b1; ready = 1'b1; clr = 1'b0;
        m_reset();
        cyc(3);
        check_zero("reset");
        rst = 1'b0;
        cyc(6);

        // Nominal frame with latency measurement from the LR pin fall
        send_frame(32'h2A5C3, 32'h15A3C, 18, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        lr = 1'b0;
        m_latch(1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!o_valid && n < 20);
        chk("latency", 64'(n), 64'(SS + 2));
        chk("nominal_left", 64'(o_left), 64'(18'h2A5C3));
        chk("nominal_right", 64'(o_right), 64'(18'h15A3C));
        cyc(1);
        chk("valid_pulse", 64'(o_valid), 64'(0));
        cyc(8);
        lr = 1'b1;
        cyc(8);
        check_flags("nominal");

        // Backpressure across two frames, one-cycle accept, then overrun
        ready = 1'b0;
        cyc(4);
        send_frame(32'h00001, 32'h3FFFF, 18, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(32'h12345, 32'h0ABCD, 18, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_hold_left", 64'(o_left), 64'(18'h00001));
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        chk("b2b_valid", 64'(o_valid), 64'(1));
        chk("b2b_left", 64'(o_left), 64'(18'h12345));
        chk("b2b_right", 64'(o_right), 64'(18'h0ABCD));
        send_frame(32'h11111, 32'h22222, 18, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(32'h33333, 32'h04444, 18, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("overrun_set", 64'(o_overrun), 64'(1));
        check_flags("bp");
        ready = 1'b1;
        cyc(20);
        chk("bp_drained", 64'(exp_q.size()), 64'(0));
        pulse_clr();
        check_flags("bp_clr");

        // Short word raises the length error; a following good word still delivers
        send_frame(32'h0F0F0, 32'h1A5A5, 17, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("len_err_set", 64'(o_len_err), 64'(1));
        send_frame(32'h2BEEF, 32'h1CAFE, 18, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        check_flags("len");
        pulse_clr();
        chk("len_err_clr", 64'(o_len_err), 64'(0));

        // 18th CK rise and LL fall land in the same cycle
        send_frame(32'h3C3C3, 32'h0C3C3, 18, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("coinc_len_err", 64'(o_len_err), 64'(0));
        check_flags("coinc");

        // Reset mid-word while a pair is held and flags are set
        ready = 1'b0;
        cyc(4);
        send_frame(32'h15555, 32'h2AAAA, 17, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(32'h001FF, 32'h00100, 9, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        m_reset();
        check_zero("midword_reset");
        ready = 1'b1;
        cyc(4);
        send_frame(32'h3A1B2, 32'h0C4D5, 18, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        check_flags("post_reset");

        // LR before LL: pair still correct and unswapped
        send_frame(32'h1E1E1, 32'h21212, 18, 4, 1'b1, 1'b1, 1'b1, 1'b0);
        check_flags("order");

        // Randomized frames: data, length, order, coincidence, backpressure, clears
        for (int f = 0; f < 30; f++) begin
            half  = $urandom_range(4, 6);
            n     = $urandom_range(0, 99);
            nbits = (n < 85) ? 18 : ((n < 93) ? 17 : 19);
            rf    = ($urandom_range(0, 1) == 1);
            co    = !rf && ($urandom_range(0, 99) < 15);
            ready = ($urandom_range(0, 99) < 75);
            cyc(8);
            send_frame($urandom, $urandom, nbits, half, 1'b1, 1'b1, rf, co);
            check_flags("rand");
            if ($urandom_range(0, 99) < 20) pulse_clr();
        end

        ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("final_drain", 64'(exp_q.size()), 64'(0));
        cyc(4);
        chk("final_valid", 64'(o_valid), 64'(0));
        check_flags("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
